kernel_pr_write_back_start_ctrl: RTL and testbench
==================================================

// Module: kernel_pr_write_back_start_ctrl
// PURPOSE
// - Downstream consumer of the 1-bit start-token FIFO feeding the write_back dataflow process.
// - Pops one start token per task and drives the ap_ctrl_hs handshake (ap_start/ap_ready/ap_done) of write_back.
// - Tracks tasks in flight, capped at MAX_INFLIGHT, and exposes task/done counters plus a sticky protocol-error flag.
// PARAMETERS
// - MAX_INFLIGHT  2   max tasks accepted (ap_ready seen) but not yet done; range 1..15
// - CNT_W         32  width of task_cnt / done_cnt (and stall_cnt when enabled)
// PORTS
// - clk           in   1      clock
// - reset         in   1      synchronous, active-high reset
// - start_empty_n in   1      start FIFO has a token
// - start_read    out  1      pop strobe to start FIFO (FIFO read_ce is tied 1)
// - start_dout    in   1      token value; ignored, always 1'b1
// - wb_ap_start   out  1      ap_start to write_back
// - wb_ap_ready   in   1      write_back accepted current start
// - wb_ap_done    in   1      write_back finished one task (1-cycle pulse)
// - busy          out  1      state!=S_IDLE or inflight!=0
// - task_cnt      out  CNT_W  tasks accepted since reset (ap_start&ap_ready)
// - done_cnt      out  CNT_W  ap_done pulses counted since reset
// - err_underflow out  1      sticky: ap_done seen with inflight==0
// - stall_cnt     out  CNT_W  only with KERNEL_PR_WB_PERF_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=S_IDLE, inflight=0; wb_ap_start=0, start_read=0, busy=0, task_cnt=0, done_cnt=0, err_underflow=0.
// - Reset mid-task drops wb_ap_start next edge; tokens already popped are discarded, not replayed.
// - can_pop = start_empty_n & (inflight_next_free), where inflight_next_free = (inflight + pend) < MAX_INFLIGHT,
//   pend = 1 while in S_START (issued, not yet accepted).
// - start_read is combinational from registered state + start_empty_n; never asserted when start_empty_n=0.
// - FSM (2 states):
//   S_IDLE : start_read = can_pop; if start_read -> S_START next cycle (wb_ap_start=1 registered).
//   S_START: wb_ap_start=1 held until wb_ap_ready=1 (ap_ctrl_hs: start never dropped before ready).
//            on wb_ap_ready: if can_pop(after accept) pop in same cycle, stay S_START (back-to-back, 1 task/cycle);
//            else -> S_IDLE, wb_ap_start=0 next cycle.
// - Latency: token visible (start_empty_n=1) at cycle T, idle -> start_read at T, wb_ap_start=1 at T+1.
// - inflight (4 bits): +1 on accept (S_START & wb_ap_ready), -1 on wb_ap_done; both same cycle -> unchanged.
// - wb_ap_done with inflight==0 and no accept in same cycle: inflight stays 0, err_underflow<=1 (cleared only by reset),
//   done_cnt still increments.
// - inflight==MAX_INFLIGHT: no pop; pop resumes the cycle after wb_ap_done lowers inflight (ready in S_IDLE same cycle as
//   done is not forwarded combinationally; done is registered into inflight first).
// - Counters wrap modulo 2^CNT_W silently; task_cnt +1 per accept, done_cnt +1 per wb_ap_done.
// - wb_ap_ready while not in S_START is ignored.
// CONFIGURATION
// - KERNEL_PR_WB_PERF_EN defined: port stall_cnt present; +1 each cycle wb_ap_start=1 & wb_ap_ready=0,
//   plus each cycle start_empty_n=1 blocked by inflight cap; reset 0, wraps.
// - Undefined: stall_cnt port and logic absent; all other behaviour identical.
// TESTING
// - Reset, FIFO empty 20 cycles -> start_read=0, wb_ap_start=0, busy=0, counters 0.
// - One token, ready 3 cycles after start, done 10 cycles later -> exactly one start_read pulse, wb_ap_start high 3 cycles,
//   task_cnt=1, done_cnt=1, busy falls cycle after done.
// - 4 tokens queued, ready tied 1, done never, MAX_INFLIGHT=2 -> 2 pops back-to-back, then start_read=0; one done -> one
//   more pop; task_cnt=3.
// - Accept and done in same cycle with inflight=1 -> inflight stays 1, task_cnt and done_cnt both +1.
// - wb_ap_done pulse at inflight=0 -> err_underflow=1 and stays 1 until reset; inflight stays 0.
// - Reset asserted while wb_ap_start=1 -> next cycle wb_ap_start=0, all counters 0; with KERNEL_PR_WB_PERF_EN, ready held low
//   5 cycles before reset -> stall_cnt=5 then 0.

Source files
------------

// File: rtl/kernel_pr_write_back_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pr_write_back_start_ctrl
// Description : Consumes start tokens from the 1-bit start FIFO and drives
//               the ap_ctrl_hs start/ready/done handshake of write_back.
//               Limits tasks in flight to MAX_INFLIGHT and keeps task/done
//               counters plus a sticky underflow error flag.
//               Optional macro KERNEL_PR_WB_PERF_EN adds the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_pr_write_back_start_ctrl #(
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_empty_n,
    output logic             start_read,
    input  logic             start_dout,
    output logic             wb_ap_start,
    input  logic             wb_ap_ready,
    input  logic             wb_ap_done,
    output logic             busy,
    output logic [CNT_W-1:0] task_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err_underflow
`ifdef KERNEL_PR_WB_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Inflight cap widened by one bit so inflight + pending never overflows
    // the comparison.
    localparam logic [4:0] c_MAX_INFLIGHT = 5'(MAX_INFLIGHT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_START = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_inflight;
    logic [3:0]       w_inflight_next;
    logic [CNT_W-1:0] r_task_cnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic             r_err_underflow;

    logic             w_pend;
    logic             w_accept;
    logic             w_room;
    logic             w_can_pop;
    logic             w_start_read;
    logic             w_underflow;

    // The token value carries no information; every token means "start".
    logic             w_unused_dout;
    assign w_unused_dout = start_dout;

    // A start has been issued but not yet accepted while in S_START.
    assign w_pend    = (r_state == S_START);
    assign w_accept  = w_pend & wb_ap_ready;

    // Room check uses registered inflight only; a done in this cycle frees a
    // slot starting next cycle.
    assign w_room    = (({1'b0, r_inflight} + {4'b0000, w_pend}) < c_MAX_INFLIGHT);
    assign w_can_pop = start_empty_n & w_room;

    // Done without any task outstanding (and no accept to cover it).
    assign w_underflow = wb_ap_done & ~w_accept & (r_inflight == 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and FIFO pop strobe; in S_START a new token is only popped
    // in the cycle the current start is accepted.
    always_comb begin
        w_state_next = r_state;
        w_start_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_start_read = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (wb_ap_ready) begin
                    if (w_can_pop) begin
                        w_start_read = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Inflight bookkeeping: accept adds one, done removes one, both cancel;
    // a done at zero leaves the count pinned at zero.
    always_comb begin
        w_inflight_next = r_inflight;
        if (w_accept && !wb_ap_done) begin
            w_inflight_next = r_inflight + 4'd1;
        end else if (!w_accept && wb_ap_done && (r_inflight != 4'd0)) begin
            w_inflight_next = r_inflight - 4'd1;
        end
    end

    // Inflight register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 4'd0;
        end else begin
            r_inflight <= w_inflight_next;
        end
    end

    // Task/done counters (wrap silently) and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_task_cnt      <= '0;
            r_done_cnt      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_task_cnt <= r_task_cnt + 1'b1;
            end
            if (wb_ap_done) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

`ifdef KERNEL_PR_WB_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall_hs;
    logic             w_stall_cap;

    // Handshake stall: start is up but write_back has not accepted it.
    assign w_stall_hs  = w_pend & ~wb_ap_ready;
    // Cap stall: a token is waiting and the FSM could pop now but the
    // inflight limit prevents it.
    assign w_stall_cap = start_empty_n & ~w_room & (~w_pend | wb_ap_ready);

    // Stall cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall_hs) + CNT_W'(w_stall_cap);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign start_read    = w_start_read;
    assign wb_ap_start   = w_pend;
    assign busy          = w_pend | (r_inflight != 4'd0);
    assign task_cnt      = r_task_cnt;
    assign done_cnt      = r_done_cnt;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_kernel_pr_write_back_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_pr_write_back_start_ctrl
// Description : Directed plus randomized bench for the write_back start
//               controller, checked every cycle against a transaction-level
//               model of the start/ready/done rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_pr_write_back_start_ctrl;

    localparam int MAXI = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_empty_n;
    logic        start_read;
    logic        start_dout;
    logic        wb_ap_start;
    logic        wb_ap_ready;
    logic        wb_ap_done;
    logic        busy;
    logic [31:0] task_cnt;
    logic [31:0] done_cnt;
    logic        err_underflow;
`ifdef KERNEL_PR_WB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    kernel_pr_write_back_start_ctrl #(
        .MAX_INFLIGHT (MAXI),
        .CNT_W        (32)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start_empty_n (start_empty_n),
        .start_read    (start_read),
        .start_dout    (start_dout),
        .wb_ap_start   (wb_ap_start),
        .wb_ap_ready   (wb_ap_ready),
        .wb_ap_done    (wb_ap_done),
        .busy          (busy),
        .task_cnt      (task_cnt),
        .done_cnt      (done_cnt),
        .err_underflow (err_underflow)
`ifdef KERNEL_PR_WB_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;

    // Reference model: tasks in flight, whether a start is outstanding,
    // event counts, and tokens sitting in the FIFO.
    int          m_inf;
    bit          m_pend;
    logic [31:0] m_task;
    logic [31:0] m_done;
    bit          m_err;
    logic [31:0] m_stall;
    int          tokens;
    bit          chk;
    int          n_read;
    int          n_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present FIFO state, compare outputs with the model,
    // then advance the model across the rising edge.
    task automatic cycle();
        bit room;
        bit exp_read;
        bit accept;
        start_empty_n = (tokens > 0);
        #1;
        room     = ((m_inf + int'(m_pend)) < MAXI);
        exp_read = start_empty_n && room && (!m_pend || wb_ap_ready);
        accept   = m_pend && wb_ap_ready;
        if (chk) begin
            check("start_read", 32'(start_read), 32'(exp_read));
            check("wb_ap_start", 32'(wb_ap_start), 32'(m_pend));
            check("busy", 32'(busy), 32'(m_pend || (m_inf != 0)));
            check("task_cnt", task_cnt, m_task);
            check("done_cnt", done_cnt, m_done);
            check("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef KERNEL_PR_WB_PERF_EN
            check("stall_cnt", stall_cnt, m_stall);
`endif
        end
        n_read  += int'(start_read === 1'b1);
        n_start += int'(wb_ap_start === 1'b1);
        @(posedge clk);
        if (exp_read) tokens--;
        if (reset) begin
            m_inf = 0; m_pend = 0; m_task = 0; m_done = 0; m_err = 0; m_stall = 0;
        end else begin
            m_stall += 32'(m_pend && !wb_ap_ready)
                     + 32'(start_empty_n && !room && (!m_pend || wb_ap_ready));
            if (accept && !wb_ap_done)      m_inf++;
            else if (!accept && wb_ap_done) begin
                if (m_inf == 0) m_err = 1;
                else            m_inf--;
            end
            m_task += 32'(accept);
            m_done += 32'(wb_ap_done);
            m_pend  = exp_read || (m_pend && !wb_ap_ready);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_ap_ready = 1'b0; wb_ap_done = 1'b0; start_dout = 1'b1;
        tokens = 0; start_empty_n = 1'b0; chk = 0;
        m_inf = 0; m_pend = 0; m_task = 0; m_done = 0; m_err = 0; m_stall = 0;
        n_read = 0; n_start = 0;
        @(negedge clk);
        cycle();
        chk = 1;
        do_reset();

        // Empty FIFO for 20 cycles: nothing moves.
        n_read = 0; n_start = 0;
        repeat (20) cycle();
        check("t1_reads", 32'(n_read), 32'd0);
        check("t1_starts", 32'(n_start), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_task", task_cnt, 32'd0);

        // Single token, ready three cycles into start, done ten cycles later.
        n_read = 0; n_start = 0;
        tokens = 1;
        cycle();
        cycle(); cycle();
        wb_ap_ready = 1'b1; cycle(); wb_ap_ready = 1'b0;
        repeat (9) cycle();
        check("t2_busy_before_done", 32'(busy), 32'd1);
        wb_ap_done = 1'b1; cycle(); wb_ap_done = 1'b0;
        check("t2_busy_after_done", 32'(busy), 32'd0);
        check("t2_reads", 32'(n_read), 32'd1);
        check("t2_starts", 32'(n_start), 32'd3);
        check("t2_task", task_cnt, 32'd1);
        check("t2_done", done_cnt, 32'd1);

        // Four tokens, ready tied high, inflight cap of two.
        do_reset();
        n_read = 0;
        tokens = 4; wb_ap_ready = 1'b1;
        repeat (8) cycle();
        check("t3_reads_capped", 32'(n_read), 32'd2);
        check("t3_task_capped", task_cnt, 32'd2);
        wb_ap_done = 1'b1; cycle(); wb_ap_done = 1'b0;
        repeat (4) cycle();
        check("t3_reads_after_done", 32'(n_read), 32'd3);
        check("t3_task_after_done", task_cnt, 32'd3);
        wb_ap_ready = 1'b0; tokens = 0;

        // Accept and done in the same cycle with one task in flight.
        do_reset();
        tokens = 2; wb_ap_ready = 1'b1;
        cycle(); cycle();
        wb_ap_done = 1'b1; cycle(); wb_ap_done = 1'b0; wb_ap_ready = 1'b0;
        check("t4_task", task_cnt, 32'd2);
        check("t4_done", done_cnt, 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        wb_ap_done = 1'b1; cycle(); wb_ap_done = 1'b0;
        check("t4_busy_drained", 32'(busy), 32'd0);
        check("t4_no_err", 32'(err_underflow), 32'd0);

        // Reset while start is held and ready is low.
        tokens = 1; wb_ap_ready = 1'b0;
        cycle();
        repeat (5) cycle();
        check("t6_start_held", 32'(wb_ap_start), 32'd1);
`ifdef KERNEL_PR_WB_PERF_EN
        check("t6_stall_5", stall_cnt, 32'd5);
`endif
        do_reset();
        check("t6_start_dropped", 32'(wb_ap_start), 32'd0);
        check("t6_task_zero", task_cnt, 32'd0);
        check("t6_done_zero", done_cnt, 32'd0);
`ifdef KERNEL_PR_WB_PERF_EN
        check("t6_stall_zero", stall_cnt, 32'd0);
`endif

        // Done with nothing in flight sets a sticky error.
        wb_ap_done = 1'b1; cycle(); wb_ap_done = 1'b0;
        check("t5_err_set", 32'(err_underflow), 32'd1);
        check("t5_done_cnt", done_cnt, 32'd1);
        repeat (5) cycle();
        check("t5_err_sticky", 32'(err_underflow), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        do_reset();
        check("t5_err_cleared", 32'(err_underflow), 32'd0);

        // Randomized traffic against the model.
        repeat (1500) begin
            if (tokens == 0 && ($urandom % 4) == 0) tokens = int'($urandom_range(1, 5));
            wb_ap_ready = (($urandom % 3) != 0);
            wb_ap_done  = (m_inf > 0) && (($urandom % 3) == 0);
            cycle();
        end
        wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
        check("rand_no_err", 32'(err_underflow), 32'd0);
        do_reset();
        check("final_task_zero", task_cnt, 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
